// File: rtl/rgb_matrix_driver.sv
// rgb_matrix_driver: scans one 8x8 common-anode RGB LED matrix from a
// 64-entry, 12-bit frame buffer using 15-slot, 4-bit-per-channel PWM.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset (frame buffer is kept)
//   wr_en        pixel write strobe, one pixel per cycle
//   wr_addr      pixel address {row[2:0], col[2:0]}
//   wr_data      pixel value {red[3:0], green[3:0], blue[3:0]}
//   c            row anodes, active low, bit n = row n
//   r, g, b      column cathodes, active low, bit n = column n
//   frame_start  one-cycle pulse in blanking cycle 0 of row 0
module rgb_matrix_driver #(
    parameter int unsigned SLOT_CYCLES  = 200,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [11:0] wr_data,
    output logic [7:0]  c,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        frame_start
);

    localparam int unsigned BW = $clog2(BLANK_CYCLES);
    localparam int unsigned SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [SW-1:0] SCNT_LAST  = SW'(SLOT_CYCLES - 1);
    localparam logic [3:0]    SLOT_LAST  = 4'd14;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } pixel_t;

    // Control state; it leads the registered outputs by one cycle, so the
    // first cycle after reset release shows blanking cycle 0 of row 0.
    logic [0:0]    state, state_nxt;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic [SW-1:0] scnt, scnt_nxt;
    logic [3:0]    slot, slot_nxt;
    logic [2:0]    row, row_nxt;

    logic [7:0] c_nxt, r_nxt, g_nxt, b_nxt;
    logic       fs_nxt;

    logic [11:0] mem [64];
    pixel_t      shadow [8];
    logic [11:0] rd_data;
    logic        rd_en;
    logic [2:0]  rd_col;
    logic        ld_vld;
    logic [2:0]  ld_col;

    // Row fetch: column k is read at the end of blanking cycle k.
    assign rd_en  = (state == ST_BLANK) && (bcnt >= BW'(1)) && (bcnt <= BW'(8));
    assign rd_col = 3'(bcnt - BW'(1));

    // Next-state logic for the BLANK/ON scan sequence.
    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        scnt_nxt  = scnt;
        slot_nxt  = slot;
        row_nxt   = row;
        case (state)
            ST_BLANK: begin
                if (bcnt == BLANK_LAST) begin
                    state_nxt = ST_ON;
                    bcnt_nxt  = '0;
                    scnt_nxt  = '0;
                    slot_nxt  = '0;
                end else begin
                    bcnt_nxt = bcnt + BW'(1);
                end
            end
            ST_ON: begin
                if (scnt == SCNT_LAST) begin
                    scnt_nxt = '0;
                    if (slot == SLOT_LAST) begin
                        state_nxt = ST_BLANK;
                        bcnt_nxt  = '0;
                        slot_nxt  = '0;
                        row_nxt   = row + 3'd1;
                    end else begin
                        slot_nxt = slot + 4'd1;
                    end
                end else begin
                    scnt_nxt = scnt + SW'(1);
                end
            end
            default: state_nxt = ST_BLANK;
        endcase
    end

    // Output values for the cycle described by the current control state.
    always_comb begin
        c_nxt  = 8'hFF;
        r_nxt  = 8'hFF;
        g_nxt  = 8'hFF;
        b_nxt  = 8'hFF;
        fs_nxt = 1'b0;
        if (state == ST_BLANK) begin
            fs_nxt = (row == 3'd0) && (bcnt == '0);
        end else begin
            c_nxt = ~(8'h01 << row);
            for (int k = 0; k < 8; k++) begin
                r_nxt[k] = ~(shadow[k].red   > slot);
                g_nxt[k] = ~(shadow[k].green > slot);
                b_nxt[k] = ~(shadow[k].blue  > slot);
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BLANK;
            bcnt        <= '0;
            scnt        <= '0;
            slot        <= '0;
            row         <= '0;
            c           <= 8'hFF;
            r           <= 8'hFF;
            g           <= 8'hFF;
            b           <= 8'hFF;
            frame_start <= 1'b0;
            ld_vld      <= 1'b0;
            ld_col      <= '0;
        end else begin
            state       <= state_nxt;
            bcnt        <= bcnt_nxt;
            scnt        <= scnt_nxt;
            slot        <= slot_nxt;
            row         <= row_nxt;
            c           <= c_nxt;
            r           <= r_nxt;
            g           <= g_nxt;
            b           <= b_nxt;
            frame_start <= fs_nxt;
            ld_vld      <= rd_en;
            ld_col      <= rd_col;
        end
    end

    // Frame buffer: read-first, so a same-cycle write to the read address
    // returns the old value. Writes are accepted even during reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[{row, rd_col}];
        end
    end

    // Row shadow load; PWM only ever looks at the shadow.
    always_ff @(posedge clk) begin
        if (ld_vld) begin
            shadow[ld_col] <= pixel_t'(rd_data);
        end
    end

endmodule

// File: doc/rgb_matrix_driver.md
# rgb_matrix_driver

Scans one 8x8 common-anode RGB LED matrix on the clock shield. Holds a 64-pixel, 12-bit-per-pixel frame buffer and drives it row by row with 4-bit-per-channel PWM. The top level instantiates two copies, one per display, feeding `d1_*` and `d2_*`. Clock and time logic write pixels through a simple write port.

## Interface
- `SLOT_CYCLES`, default 200: clock cycles per PWM slot; must be ≥1.
- `BLANK_CYCLES`, default 64: clock cycles per inter-row blanking interval; must be ≥10.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: reset. **One clock; reset is synchronous and active-high.**
- `wr_en` in 1: pixel write strobe, one pixel per cycle.
- `wr_addr` in 6: pixel address, {row[2:0], col[2:0]}.
- `wr_data` in 12: {red[3:0], green[3:0], blue[3:0]} intensity.
- `c` out 8: row anodes, active low; bit n = row n.
- `r`, `g`, `b` out 8 each: column cathodes, active low; bit n = column n.
- `frame_start` out 1: single-cycle pulse at the start of each frame.

## Operation
- Frame buffer: 64x12 RAM, synchronous read, read-first.
  - Initialised to zero at configuration; not cleared by `rst`.
  - A write with `wr_en`=1 updates entry `wr_addr` at the clock edge.
  - Writes are accepted in every state, including during reset.
- Row shadow: 8x12 registers holding the row currently displayed. PWM reads only the shadow, so RAM writes never tear a row mid-display.
- FSM states: BLANK and ON.
- BLANK, lasting BLANK_CYCLES cycles:
  - `c`, `r`, `g`, `b` are all 8'hFF.
  - In cycles 0..7 the FSM issues RAM reads of {row, k} for k=0..7.
  - Read data lands in shadow[k] one cycle later, so the shadow is complete by cycle 9.
  - In the last cycle it moves to ON, with slot counter s=0 and the slot cycle counter at 0.
- ON, lasting 15·SLOT_CYCLES cycles:
  - `c` = ~(8'b1 << row).
  - `r[k]` = ~(shadow[k].red > s); same rule for `g` and `b`.
  - s increments every SLOT_CYCLES cycles over 0..14.
  - At the end of slot 14 the FSM goes to BLANK and row increments mod 8 (7 wraps to 0).
- Duty: level L lights for L of 15 slots. Level 0 is never lit; level 15 is lit for the whole ON interval.
- `frame_start`: asserted in BLANK cycle 0 when row=0, otherwise 0.
- All outputs are registered. No combinational path from any input to any output.
- Read/write collision: a write to the address being read in the same cycle loads the old value into the shadow. The new value appears on the next frame.

## Timing
- Row period = BLANK_CYCLES + 15·SLOT_CYCLES. Defaults: 3064 cycles.
- Frame period = 8 × row period. Defaults: 24512 cycles, about 2.04 kHz at 50 MHz.
- Reset, i.e. `rst`=1 sampled at an edge:
  - Next cycle: state=BLANK, row=0, all counters 0, `c`/`r`/`g`/`b`=8'hFF, `frame_start`=0.
  - Reset mid-ON blanks immediately and discards the remainder of the row.
- First cycle after `rst` deasserts is BLANK cycle 0 of row 0, with `frame_start`=1.
- First lit output is at cycle BLANK_CYCLES after reset release.
- Anodes and cathodes change on the same edge at BLANK→ON. On ON→BLANK all go to 8'hFF on the same edge.
- No glitch-free guarantee is required beyond registered outputs.
- Write-to-display latency: a pixel is shown from the next load of its row, between 1 and 8 row periods later.

## Test plan
Bench parameters: SLOT_CYCLES=4, BLANK_CYCLES=10, giving row period 70 and frame 560.
1. **Reset values.** Hold `rst` 3 cycles. Then all outputs are 8'hFF and `frame_start`=0. First post-reset cycle has `frame_start`=1. Repeats every 560 cycles.
2. **Single full-red pixel.** Write 0x000 to all 64 entries, then 0xF00 to addr {2,5}.
   - Row 2 ON: `c`=8'hFB, `r`=8'hDF for all 60 cycles, `g`=`b`=8'hFF.
   - Every other row: `c` asserted with `r`/`g`/`b`=8'hFF.
3. **Mid-level duty.** Pixel (0,0) = 0x830.
   - `r[0]` low for exactly 32 of 60 ON cycles, first 8 slots.
   - `g[0]` low for 12 cycles.
   - `b[0]` never low.
4. **Write during scan.** Change pixel (3,1) from 0xFFF to 0x000 while row 3 is ON.
   - The current row still shows full white.
   - The next row-3 ON shows all cathodes high.
5. **Collision.** Write addr {4,k} in the exact cycle it is read during BLANK. The old value is displayed that frame and the new value the following frame.
6. **Reset mid-row.** Assert `rst` during row 5, slot 7. Next cycle all outputs are 8'hFF. After release, row 0 restarts with `frame_start` pulsed.
